// File: rtl/clock_pkg.sv
// Shared constants for the pulse train generator: FSM encoding and default widths.
package clock_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int NUM_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;
endpackage

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle between a pulse train requester and the generator.
interface pulse_train_gen_if import clock_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] half_period;
  logic [NUM_W-1:0] num_pulses;
  logic             cp;
  logic             pedge;
  logic             nedge;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, half_period, num_pulses,
    input  cp, pedge, nedge, busy, done
  );

  modport slave (
    input  start, abort, half_period, num_pulses,
    output cp, pedge, nedge, busy, done
  );
endinterface

// File: rtl/pulse_train_gen_phase_counter.sv
// Phase timer: loaded with (cycles - 1) at each phase start, term flags the last cycle.
module phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             term
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt_q <= '0;
    else if (load)          cnt_q <= load_val;
    else if (cnt_q != '0)   cnt_q <= cnt_q - CNT_W'(1);
  end

  assign term = (cnt_q == '0);
endmodule

// File: rtl/pulse_train_gen.sv
// Square-wave pulse train generator: IDLE/HIGH/LOW FSM with registered outputs.
module pulse_train_gen import clock_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  pulse_train_gen_if.slave bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] hp_q, hp_sel, hp_m1;
  logic [NUM_W-1:0] n_q, pcnt_q;
  logic             cp_q, pedge_q, nedge_q, busy_q, done_q;
  logic             cp_d, pedge_d, nedge_d, busy_d, done_d;
  logic             load, latch, pcnt_inc, term, last;

  // In IDLE the phase length comes straight from the input so the first
  // HIGH phase is timed in the same edge that latches it.
  assign hp_sel = (state_q == IDLE) ? bus.half_period : hp_q;
  assign hp_m1  = (hp_sel == '0) ? '0 : hp_sel - CNT_W'(1);
  // Compare against N-1 so the counter never needs to hold N (no wrap at max N).
  assign last   = (n_q != '0) && (pcnt_q == n_q - NUM_W'(1));

  phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (hp_m1),
    .term     (term)
  );

  always_comb begin
    state_d  = state_q;
    cp_d     = 1'b0;
    pedge_d  = 1'b0;
    nedge_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    latch    = 1'b0;
    pcnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = HIGH;
          cp_d    = 1'b1;
          pedge_d = 1'b1;
          busy_d  = 1'b1;
          load    = 1'b1;
          latch   = 1'b1;
        end
      end
      HIGH: begin
        if (bus.abort) begin
          state_d = IDLE;
          nedge_d = 1'b1;
        end else if (term) begin
          state_d = LOW;
          nedge_d = 1'b1;
          busy_d  = 1'b1;
          load    = 1'b1;
        end else begin
          cp_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      LOW: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (term && last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (term) begin
          state_d  = HIGH;
          cp_d     = 1'b1;
          pedge_d  = 1'b1;
          busy_d   = 1'b1;
          load     = 1'b1;
          pcnt_inc = (n_q != '0);
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cp_q    <= 1'b0;
      pedge_q <= 1'b0;
      nedge_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hp_q    <= '0;
      n_q     <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cp_q    <= cp_d;
      pedge_q <= pedge_d;
      nedge_q <= nedge_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (latch) begin
        hp_q   <= bus.half_period;
        n_q    <= bus.num_pulses;
        pcnt_q <= '0;
      end else if (pcnt_inc) begin
        pcnt_q <= pcnt_q + NUM_W'(1);
      end
    end
  end

  assign bus.cp    = cp_q;
  assign bus.pedge = pedge_q;
  assign bus.nedge = nedge_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen; outputs checked as {cp,pedge,nedge,busy,done}.
module tb_pulse_train_gen;
  typedef logic [4:0] vec_q_t[$];

  logic clk;
  logic reset;
  int   nvec;
  int   nmis;

  pulse_train_gen_if #(.CNT_W(16), .NUM_W(8)) bus ();

  pulse_train_gen #(.CNT_W(16), .NUM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {bus.cp, bus.pedge, bus.nedge, bus.busy, bus.done};
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    assert (got === want) else begin
      nmis++;
      $error("FAIL %s cyc %0d: got %0h want %0h", tag, cyc, got, want);
    end
  endtask

  // Steps one cycle per expected vector; start drops after the first edge,
  // abort is a one-cycle pulse raised after cycle abort_at is checked, and
  // poke_at re-requests start with new parameters mid-train.
  task automatic run(input string tag, input vec_q_t exp, input int abort_at, input int poke_at);
    for (int i = 0; i < exp.size(); i++) begin
      @(posedge clk); #1;
      bus.abort = 1'b0;
      if (i == 0 || i == poke_at + 1) bus.start = 1'b0;
      chk(tag, i + 1, 32'(obs()), 32'(exp[i]));
      if (i == abort_at) bus.abort = 1'b1;
      if (i == poke_at) begin
        bus.start       = 1'b1;
        bus.half_period = 16'd1;
        bus.num_pulses  = 8'd3;
      end
    end
  endtask

  task automatic go(input logic [15:0] h, input logic [7:0] n);
    bus.half_period = h;
    bus.num_pulses  = n;
    bus.start       = 1'b1;
  endtask

  initial begin
    int npe, nov, dcyc;
    nvec = 0;
    nmis = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.half_period = '0;
    bus.num_pulses = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 0, 32'(obs()), 32'h0);
    reset = 1'b0;

    // H=3, N=2
    go(16'd3, 8'd2);
    run("h3n2", '{5'b11010, 5'b10010, 5'b10010, 5'b00110, 5'b00010, 5'b00010,
                  5'b11010, 5'b10010, 5'b10010, 5'b00110, 5'b00010, 5'b00010,
                  5'b00001, 5'b00000}, -1, -1);

    // H=0 behaves as H=1
    go(16'd0, 8'd1);
    run("h0n1", '{5'b11010, 5'b00110, 5'b00001, 5'b00000}, -1, -1);

    // continuous, abort while high (cycle 9)
    go(16'd2, 8'd0);
    run("cont_abort_hi", '{5'b11010, 5'b10010, 5'b00110, 5'b00010, 5'b11010,
                           5'b10010, 5'b00110, 5'b00010, 5'b11010, 5'b00100,
                           5'b00000}, 8, -1);

    // continuous, abort while low: no nedge
    go(16'd2, 8'd0);
    run("cont_abort_lo", '{5'b11010, 5'b10010, 5'b00110, 5'b00010, 5'b00000,
                           5'b00000}, 3, -1);

    // start and new parameters mid-train are ignored
    go(16'd4, 8'd1);
    run("busy_ignore", '{5'b11010, 5'b10010, 5'b10010, 5'b10010, 5'b00110,
                         5'b00010, 5'b00010, 5'b00010, 5'b00001, 5'b00000}, -1, 1);

    // start with abort in IDLE
    go(16'd2, 8'd1);
    bus.abort = 1'b1;
    run("start_abort", '{5'b00000, 5'b00000}, -1, -1);

    // reset during HIGH
    go(16'd3, 8'd1);
    run("rst_pre", '{5'b11010, 5'b10010}, -1, -1);
    #2 reset = 1'b1;
    #1 chk("rst_async", 0, 32'(obs()), 32'h0);
    @(posedge clk); #1;
    chk("rst_hold", 0, 32'(obs()), 32'h0);
    reset = 1'b0;
    run("rst_after", '{5'b00000, 5'b00000}, -1, -1);
    go(16'd1, 8'd1);
    run("rst_restart", '{5'b11010, 5'b00110, 5'b00001, 5'b00000}, -1, -1);

    // maximum pulse count, H=1: 255 pulses, done at cycle 511
    go(16'd1, 8'd255);
    npe = 0;
    nov = 0;
    dcyc = 0;
    for (int c = 1; c <= 520 && dcyc == 0; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.pedge) npe++;
      if (bus.pedge && (bus.nedge || bus.done)) nov++;
      if (bus.done) dcyc = c;
    end
    chk("max_pulses", 0, 32'(npe), 32'd255);
    chk("max_done_cyc", 0, 32'(dcyc), 32'd511);
    chk("max_overlap", 0, 32'(nov), 32'd0);
    @(posedge clk); #1;
    chk("max_idle", 0, 32'(obs()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
